// File: rtl/fp_mult_unpack_stage_if.sv
// rtl/fp_mult_unpack_stage_if.sv - operand-in / unpacked-out handshake bundle for fp_mult_unpack_stage
`ifndef GET_EXP_LEN
`define FP16 16
`define FP32 32
`define FP64 64
`define GET_EXP_LEN(f) ((f) == 16 ? 5 : (f) == 64 ? 11 : 8)
`define GET_MANT_LEN(f) ((f) == 16 ? 10 : (f) == 64 ? 52 : 23)
`define GET_FP_LEN(f) (f)
`endif

interface fp_mult_unpack_stage_if #(
   parameter int data_format = `FP32
);
   localparam int E = `GET_EXP_LEN(data_format);
   localparam int M = `GET_MANT_LEN(data_format);
   localparam int W = `GET_FP_LEN(data_format);

   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic           sign;
   logic [E+1:0]   a_exp;
   logic [E+1:0]   b_exp;
   logic [M:0]     a_frac;
   logic [M:0]     b_frac;
   logic           a_zero;
   logic           b_zero;
   logic           a_inf;
   logic           b_inf;
   logic           a_nan;
   logic           b_nan;
   logic           a_sub;
   logic           b_sub;

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sign, a_exp, b_exp, a_frac, b_frac,
             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_sub, b_sub
   );

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sign, a_exp, b_exp, a_frac, b_frac,
             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_sub, b_sub
   );
endinterface

// File: rtl/fp_mult_unpack_stage.sv
// rtl/fp_mult_unpack_stage.sv - registered FP multiplier operand unpack with 2-entry skid buffer
// Optional FP_MULT_DAZ_EN: subnormals decode as zero (sub flag kept), no LZC/shifter built.
`ifndef GET_EXP_LEN
`define FP16 16
`define FP32 32
`define FP64 64
`define GET_EXP_LEN(f) ((f) == 16 ? 5 : (f) == 64 ? 11 : 8)
`define GET_MANT_LEN(f) ((f) == 16 ? 10 : (f) == 64 ? 52 : 23)
`define GET_FP_LEN(f) (f)
`endif

module fp_mult_unpack_stage #(
   parameter int data_format = `FP32
) (
   input logic                  clk,
   input logic                  rst_n,
   fp_mult_unpack_stage_if.slave bus
);
   localparam int E    = `GET_EXP_LEN(data_format);
   localparam int M    = `GET_MANT_LEN(data_format);
   localparam int W    = `GET_FP_LEN(data_format);
   localparam int BIAS = (1 << (E - 1)) - 1;
   localparam int EW   = E + 2;
   localparam int FW   = M + 1;

   typedef struct packed {
      logic [EW-1:0] exp;
      logic [FW-1:0] frac;
      logic          zero;
      logic          inf;
      logic          nan;
      logic          sub;
   } op_t;

   typedef struct packed {
      logic sign;
      op_t  a;
      op_t  b;
   } pair_t;

`ifndef FP_MULT_DAZ_EN
   localparam int LZW = $clog2(M + 1);

   function automatic logic [LZW-1:0] lzc(input logic [M-1:0] m);
      logic [LZW-1:0] cnt;
      logic           found;
      cnt   = '0;
      found = 1'b0;
      for (int i = M - 1; i >= 0; i--) begin
         if (!found) begin
            if (m[i]) found = 1'b1;
            else      cnt   = cnt + LZW'(1);
         end
      end
      return cnt;
   endfunction
`endif

   function automatic op_t decode(input logic [W-1:0] x);
      logic [E-1:0] e;
      logic [M-1:0] m;
      op_t          d;
`ifndef FP_MULT_DAZ_EN
      logic [LZW-1:0] z;
`endif
      e = x[W-2:M];
      m = x[M-1:0];
      d = '0;
      if (e == '0) begin
         if (m == '0) begin
            d.zero = 1'b1;
         end else begin
            d.sub = 1'b1;
`ifdef FP_MULT_DAZ_EN
            d.zero = 1'b1;
`else
            // Shift the leading one of the mantissa up to the hidden-bit position.
            z      = lzc(m);
            d.frac = {m, 1'b0} << z;
            d.exp  = EW'(1) - EW'(BIAS) - (EW'(z) + EW'(1));
`endif
         end
      end else if (e == '1) begin
         if (m == '0) begin
            d.inf = 1'b1;
         end else begin
            d.nan  = 1'b1;
            d.frac = {1'b1, m};
         end
      end else begin
         d.exp  = EW'(e) - EW'(BIAS);
         d.frac = {1'b1, m};
      end
      return d;
   endfunction

   pair_t in_dec;
   pair_t out_q;
   pair_t skid_q;
   logic  out_valid_q;
   logic  skid_valid_q;
   logic  in_fire;

   assign in_dec  = {bus.a[W-1] ^ bus.b[W-1], decode(bus.a), decode(bus.b)};
   assign in_fire = bus.in_valid && !skid_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else if (!out_valid_q || bus.out_ready) begin
         // Output slot frees this cycle: the skid entry is older, so it goes first.
         if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else if (in_fire) begin
            out_q       <= in_dec;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (in_fire) begin
         skid_q       <= in_dec;
         skid_valid_q <= 1'b1;
      end
   end

   assign bus.in_ready  = !skid_valid_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sign      = out_q.sign;
   assign bus.a_exp     = out_q.a.exp;
   assign bus.a_frac    = out_q.a.frac;
   assign bus.a_zero    = out_q.a.zero;
   assign bus.a_inf     = out_q.a.inf;
   assign bus.a_nan     = out_q.a.nan;
   assign bus.a_sub     = out_q.a.sub;
   assign bus.b_exp     = out_q.b.exp;
   assign bus.b_frac    = out_q.b.frac;
   assign bus.b_zero    = out_q.b.zero;
   assign bus.b_inf     = out_q.b.inf;
   assign bus.b_nan     = out_q.b.nan;
   assign bus.b_sub     = out_q.b.sub;
endmodule

// File: tb/tb_fp_mult_unpack_stage.sv
// tb/tb_fp_mult_unpack_stage.sv - scoreboard bench for fp_mult_unpack_stage (FP32)
module tb_fp_mult_unpack_stage;
   typedef logic [76:0] rec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   out_count = 0;
   int   stalls = 0;
   rec_t sbq[$];
   rec_t obs;

   fp_mult_unpack_stage_if bus ();
   fp_mult_unpack_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   assign obs = {bus.sign,
                 bus.a_exp, bus.a_frac, bus.a_zero, bus.a_inf, bus.a_nan, bus.a_sub,
                 bus.b_exp, bus.b_frac, bus.b_zero, bus.b_inf, bus.b_nan, bus.b_sub};

   function automatic logic [37:0] dec(input logic [31:0] x);
      logic [7:0]  e;
      logic [22:0] m;
      logic [9:0]  ex;
      logic [23:0] fr;
      logic [3:0]  fl;
      int          p;
      e = x[30:23]; m = x[22:0];
      ex = '0; fr = '0; fl = '0; p = 0;
      if (e == 8'd0 && m == 23'd0) begin
         fl = 4'b1000;
      end else if (e == 8'd0) begin
`ifdef FP_MULT_DAZ_EN
         fl = 4'b1001;
`else
         for (int i = 0; i < 23; i++) if (m[i]) p = i;
         fr = 24'(m) << (23 - p);
         ex = 10'(p - 149);
         fl = 4'b0001;
`endif
      end else if (e == 8'hFF) begin
         if (m == 23'd0) fl = 4'b0100;
         else begin fl = 4'b0010; fr = {1'b1, m}; end
      end else begin
         ex = 10'(int'(e) - 127);
         fr = {1'b1, m};
      end
      return {ex, fr, fl};
   endfunction

   function automatic rec_t model(input logic [31:0] x, input logic [31:0] y);
      return {x[31] ^ y[31], dec(x), dec(y)};
   endfunction

   function automatic rec_t mk(input logic s, input logic [9:0] ae, input logic [23:0] af,
                               input logic [3:0] afl, input logic [9:0] be,
                               input logic [23:0] bf, input logic [3:0] bfl);
      return {s, ae, af, afl, be, bf, bfl};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0]  e;
      logic [22:0] m;
      int          r;
      r = $urandom_range(0, 7);
      m = 23'($urandom() >> $urandom_range(9, 31));
      if ($urandom_range(0, 5) == 0) m = '0;
      if (r == 0)      e = 8'd0;
      else if (r == 1) e = 8'hFF;
      else             e = 8'($urandom_range(1, 254));
      return {1'($urandom_range(0, 1)), e, m};
   endfunction

   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         rec_t expv;
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: unexpected output %h", obs);
         end else begin
            expv = sbq.pop_front();
            if (obs !== expv) begin
               errors++;
               $display("FAIL sb_data: got %h expected %h", obs, expv);
            end
         end
         out_count++;
      end
   end

   task automatic send(input logic [31:0] x, input logic [31:0] y, input rec_t expv);
      logic accepted;
      accepted = 1'b0;
      bus.a = x; bus.b = y; bus.in_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sbq.push_back(expv);
            accepted = 1'b1;
            break;
         end
         stalls++;
      end
      checks++;
      if (!accepted) begin
         errors++;
         $display("FAIL send_timeout: in_ready=%b expected 1 within 1000 cycles", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d pending, expected 0", sbq.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL reset_data: got %h expected 0", obs);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      int base;
      base = out_count;
      bus.out_ready = 1'b1;
      send(32'h3FC00000, 32'h40000000,
           mk(1'b0, 10'h000, 24'hC00000, 4'b0000, 10'h001, 24'h800000, 4'b0000));
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL latency: out_valid=%b expected 1 one cycle after accept", bus.out_valid);
      end
      @(posedge clk); #1;
`ifdef FP_MULT_DAZ_EN
      send(32'h00000001, 32'h80400000,
           mk(1'b1, 10'h000, 24'h000000, 4'b1001, 10'h000, 24'h000000, 4'b1001));
`else
      send(32'h00000001, 32'h80400000,
           mk(1'b1, 10'h36B, 24'h800000, 4'b0001, 10'h381, 24'h800000, 4'b0001));
`endif
      send(32'h7F800000, 32'h7FC00001,
           mk(1'b0, 10'h000, 24'h000000, 4'b0100, 10'h000, 24'hC00001, 4'b0010));
      send(32'h80000000, 32'h3F800000,
           mk(1'b1, 10'h000, 24'h000000, 4'b1000, 10'h000, 24'h800000, 4'b0000));
      send(32'h00800000, 32'h7F7FFFFF,
           mk(1'b0, 10'h382, 24'h800000, 4'b0000, 10'h07F, 24'hFFFFFF, 4'b0000));
      wait_drain();
      checks++;
      if (out_count - base != 5) begin
         errors++; $display("FAIL directed_count: got %0d expected 5", out_count - base);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x[3];
      logic [31:0] y[3];
      int          base;
      logic        accepted;
      for (int i = 0; i < 3; i++) begin x[i] = rand_op(); y[i] = rand_op(); end
      base = out_count;
      bus.out_ready = 1'b0;
      send(x[0], y[0], model(x[0], y[0]));
      send(x[1], y[1], model(x[1], y[1]));
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL skid_full_in_ready: got %b expected 0", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL skid_full_out_valid: got %b expected 1", bus.out_valid);
      end
      @(posedge clk); #1;
      bus.a = x[2]; bus.b = y[2]; bus.in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
         end
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sbq.push_back(model(x[2], y[2]));
            accepted = 1'b1;
         end
      end
      checks++;
      if (!accepted) begin
         errors++; $display("FAIL b2b_accept: in_ready=%b expected 1 after release", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_drain();
      checks++;
      if (out_count - base != 3) begin
         errors++; $display("FAIL b2b_count: got %0d expected 3", out_count - base);
      end
   endtask

   task automatic test_stream();
      logic done;
      int   base;
      logic [31:0] x, y;
      base = out_count;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               x = rand_op(); y = rand_op();
               send(x, y, model(x, y));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;
      wait_drain();
      checks++;
      if (out_count - base != 100) begin
         errors++; $display("FAIL stream_count: got %0d expected 100", out_count - base);
      end
      stalls = 0;
      for (int i = 0; i < 20; i++) begin
         x = rand_op(); y = rand_op();
         send(x, y, model(x, y));
      end
      checks++;
      if (stalls != 0) begin
         errors++; $display("FAIL throughput_stalls: got %0d expected 0", stalls);
      end
      wait_drain();
   endtask

   task automatic test_async_reset();
      logic [31:0] x, y;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         x = rand_op(); y = rand_op();
         send(x, y, model(x, y));
      end
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL async_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL async_in_ready: got %b expected 1", bus.in_ready);
      end
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL async_data: got %h expected 0", obs);
      end
      sbq.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      x = 32'h40490FDB; y = 32'hC0000000;
      send(x, y, mk(1'b1, 10'h001, 24'hC90FDB, 4'b0000, 10'h001, 24'h800000, 4'b0000));
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL post_reset_latency: out_valid=%b expected 1", bus.out_valid);
      end
      @(posedge clk); #1;
      wait_drain();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stream();
      test_async_reset();
      checks++;
      if (sbq.size() != 0) begin
         errors++; $display("FAIL sb_leftover: %0d pending, expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
